nonce_sched: RTL and testbench
==============================

NONCE_SCHED -- requirements
Module: nonce_sched

Interface
REQ-001 Parameter NUM_CORES, default 4, number of hash cores the block sequences (2..16).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  job request, sampled only in IDLE.
REQ-005 num_nonces  input  8  nonces in the job (0..255), latched on accepted start.
REQ-006 output_addr  input  16  result base word address, latched on accepted start.
REQ-007 done  output  1  high exactly while state is IDLE.
REQ-008 core_start  output  NUM_CORES  one-hot, one-cycle start pulse to the selected core.
REQ-009 core_nonce  output  32  nonce for the pulsed core, zero-extended from 8 bits; valid with core_start.
REQ-010 core_valid  input  NUM_CORES  per-core level, high while the core holds a finished result, cleared by the core on its next start.
REQ-011 core_hash  input  NUM_CORES*32  per-core result word, core i at bits [32i+31:32i], valid while core_valid[i].
REQ-012 mem_we  output  1  write strobe, one word per cycle.
REQ-013 mem_addr  output  16  write address.
REQ-014 mem_write_data  output  32  write data.

Function
REQ-015 States: IDLE, RUN, FLUSH; IDLE->RUN on start; RUN->FLUSH when all nonces dispatched; FLUSH->IDLE when no core busy and no result pending.
REQ-016 start in RUN or FLUSH is ignored; latched num_nonces and output_addr are unaffected.
REQ-017 num_nonces=0: one cycle in RUN, then IDLE; no core_start, no mem_we.
REQ-018 Per-core status: FREE, BUSY (started, awaiting core_valid), PEND (result captured, awaiting write); each core also holds its 8-bit nonce.
REQ-019 Dispatch: at most one per cycle; lowest-index FREE core receives the next nonce, nonces ascend from 0; first core_start one cycle after start accepted.
REQ-020 A core whose core_start fired in cycle n ignores core_valid in cycle n+1 (stale-valid guard), sampling it from n+2.
REQ-021 Capture: BUSY core with core_valid high copies core_hash into its one-word buffer, status becomes PEND in the same edge.
REQ-022 Write-back: one PEND core per cycle, round-robin; grant pointer resets to 0 and moves to granted index+1 (mod NUM_CORES).
REQ-023 Granted write: mem_we=1, mem_addr=latched output_addr+nonce (16-bit wrap), mem_write_data=buffered word, registered, one cycle after grant; core then FREE.
REQ-024 A core freed by write-back is dispatch-eligible the following cycle, never the same cycle.
REQ-025 Capture on one core, write on another, and dispatch on a third all occur in the same cycle without stall.
REQ-026 mem_we deasserted whenever no grant; mem_addr and mem_write_data hold last value.
REQ-027 Every nonce 0..num_nonces-1 written exactly once per job; out-of-order completion yields out-of-order writes, addresses still correct.

Reset
REQ-028 reset_n low, any state: state IDLE, done=1, core_start=0, core_nonce=0, mem_we=0, mem_addr=0, mem_write_data=0, all cores FREE, grant pointer 0, nonce counter 0.
REQ-029 Reset mid-job abandons it; no further writes for that job; next start begins a fresh job at nonce 0.

Structure
REQ-030 Shared package sha_sched_pkg holds state enum, core-status enum, default NUM_CORES and NONCE_W=8.
REQ-031 One sub-module, rr_arbiter (NUM_CORES requests, one-hot grant, rotating pointer), performs write-back selection.

Verification
REQ-032 Reset, num_nonces=0, start -> done low one cycle then high; zero mem_we.
REQ-033 NUM_CORES=4, num_nonces=4, output_addr=0x0100, cores finish in fixed 70 cycles -> core_start 0001,0010,0100,1000 on consecutive cycles with nonces 0..3; writes to 0x0100..0x0103 with matching hashes; done returns high.
REQ-034 num_nonces=10, core latencies 3/50/50/50 -> core 0 reused for nonces 4..; exactly 10 writes to base+0..base+9, each once.
REQ-035 All four cores raise core_valid in the same cycle -> four writes on four consecutive cycles in order 0,1,2,3; next simultaneous batch ordered from pointer.
REQ-036 output_addr=0xFFFE, num_nonces=4 -> writes to 0xFFFE,0xFFFF,0x0000,0x0001.
REQ-037 reset_n low during FLUSH with two results pending -> no mem_we after reset; new job num_nonces=2 writes only nonces 0,1.

Source files
------------

// File: rtl/sha_sched_pkg.sv
// Shared types and constants for the nonce scheduler: FSM state, per-core
// status, sizing defaults and the write-back address helper.
package sha_sched_pkg;

  localparam int DEF_NUM_CORES = 4;
  localparam int NONCE_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } sched_state_t;

  typedef enum logic [1:0] {
    CS_FREE = 2'd0,
    CS_BUSY = 2'd1,
    CS_PEND = 2'd2
  } core_status_t;

  // Result word address: job base plus nonce, wrapping at 16 bits.
  function automatic logic [15:0] wb_addr(input logic [15:0]        base,
                                          input logic [NONCE_W-1:0] nonce);
    return base + {{(16 - NONCE_W){1'b0}}, nonce};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves to grant+1 whenever a grant is issued.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx,
  output logic          o_any
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_cand;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_cand    = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = IW'((int'(r_ptr) + k) % N);
      if (!o_any && i_req[w_cand]) begin
        o_any     = 1'b1;
        o_gnt_idx = w_cand;
      end
    end
    if (o_any) o_gnt[o_gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (o_any) begin
      r_ptr <= (o_gnt_idx == IW'(N - 1)) ? '0 : o_gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/nonce_sched.sv
// Nonce scheduler: hands nonces 0..num_nonces-1 to a pool of hash cores,
// captures each finished result and writes it to output_addr + nonce.
//
// Core handshake: core_start[i] is a one-cycle pulse carrying core_nonce;
// core_valid[i] is a level the core raises when core_hash[i] holds the result
// and drops some time after its next start. A valid seen in the cycle right
// after a start is treated as the previous result and ignored.
module nonce_sched
  import sha_sched_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [7:0]              num_nonces,
  input  logic [15:0]             output_addr,
  output logic                    done,
  output logic [NUM_CORES-1:0]    core_start,
  output logic [31:0]             core_nonce,
  input  logic [NUM_CORES-1:0]    core_valid,
  input  logic [NUM_CORES*32-1:0] core_hash,
  output logic                    mem_we,
  output logic [15:0]             mem_addr,
  output logic [31:0]             mem_write_data,
  output logic [1:0]              o_dbg_state
);

  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  sched_state_t         r_state;
  sched_state_t         w_state_nxt;

  logic [NONCE_W-1:0]   r_num;
  logic [NONCE_W-1:0]   r_cnt;
  logic [15:0]          r_base;

  core_status_t         r_cst    [NUM_CORES];
  logic [NONCE_W-1:0]   r_cnonce [NUM_CORES];
  logic [31:0]          r_buf    [NUM_CORES];
  logic [NUM_CORES-1:0] r_guard;

  logic [NUM_CORES-1:0] w_free;
  logic [NUM_CORES-1:0] w_pend;
  logic [NUM_CORES-1:0] w_gnt;
  logic [NUM_CORES-1:0] w_disp_oh;
  logic [IW-1:0]        w_free_idx;
  logic [IW-1:0]        w_gnt_idx;
  logic                 w_any_free;
  logic                 w_all_free;
  logic                 w_cnt_done;
  logic                 w_disp;
  logic                 w_gnt_any;

  always_comb begin
    w_free = '0;
    w_pend = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_free[i] = (r_cst[i] == CS_FREE);
      w_pend[i] = (r_cst[i] == CS_PEND);
    end
  end

  // Lowest-index free core wins dispatch.
  always_comb begin
    w_free_idx = '0;
    w_any_free = 1'b0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (w_free[i]) begin
        w_free_idx = IW'(i);
        w_any_free = 1'b1;
      end
    end
  end

  assign w_all_free  = &w_free;
  assign w_cnt_done  = (r_cnt == r_num);
  assign o_dbg_state = r_state;

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_cnt_done) w_state_nxt = w_all_free ? ST_IDLE : ST_FLUSH;
      ST_FLUSH: if (w_all_free) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    done      = (r_state == ST_IDLE);
    w_disp    = (r_state == ST_RUN) && !w_cnt_done && w_any_free;
    w_disp_oh = '0;
    if (w_disp) w_disp_oh[w_free_idx] = 1'b1;
    core_start = w_disp_oh;
    core_nonce = w_disp ? {{(32 - NONCE_W){1'b0}}, r_cnt} : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_num  <= '0;
      r_base <= '0;
      r_cnt  <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_num  <= num_nonces;
      r_base <= output_addr;
      r_cnt  <= '0;
    end else if (w_disp) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Dispatch, capture and write-back target distinct statuses, so the three
  // can land on different cores in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        r_cst[i]    <= CS_FREE;
        r_cnonce[i] <= '0;
        r_buf[i]    <= '0;
      end
      r_guard <= '0;
    end else begin
      r_guard <= w_disp_oh;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_disp_oh[i]) begin
          r_cst[i]    <= CS_BUSY;
          r_cnonce[i] <= r_cnt;
        end else if (r_cst[i] == CS_BUSY && core_valid[i] && !r_guard[i]) begin
          r_cst[i] <= CS_PEND;
          r_buf[i] <= core_hash[32*i +: 32];
        end else if (w_gnt[i]) begin
          r_cst[i] <= CS_FREE;
        end
      end
    end
  end

  rr_arbiter #(
    .N  (NUM_CORES),
    .IW (IW)
  ) u_wb_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_req     (w_pend),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_gnt_any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      mem_we <= w_gnt_any;
      if (w_gnt_any) begin
        mem_addr       <= wb_addr(r_base, r_cnonce[w_gnt_idx]);
        mem_write_data <= r_buf[w_gnt_idx];
      end
    end
  end

endmodule

// File: tb/tb_nonce_sched.sv
// Bench for nonce_sched: modelled hash cores with configurable latency, and a
// cycle-level reference of dispatch, capture and round-robin write-back.
module tb_nonce_sched;

  localparam int NC = 4;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [7:0]        num_nonces;
  logic [15:0]       output_addr;
  logic              done;
  logic [NC-1:0]     core_start;
  logic [31:0]       core_nonce;
  logic [NC-1:0]     core_valid;
  logic [NC*32-1:0]  core_hash;
  logic              mem_we;
  logic [15:0]       mem_addr;
  logic [31:0]       mem_write_data;
  logic [1:0]        dbg_state;

  nonce_sched #(.NUM_CORES(NC)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .num_nonces     (num_nonces),
    .output_addr    (output_addr),
    .done           (done),
    .core_start     (core_start),
    .core_nonce     (core_nonce),
    .core_valid     (core_valid),
    .core_hash      (core_hash),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .o_dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] hash_fn(input logic [31:0] s, input int n);
    return s ^ (32'(n + 1) * 32'h9E37_79B1);
  endfunction

  // reference model: core 0=free 1=working 2=result held 3=write granted
  int          m_st    [NC];
  int          m_nonce [NC];
  int          m_dcyc  [NC];
  int          m_ptr, m_num, m_next, cyc;
  bit          m_act;
  logic [15:0] m_base;
  logic [31:0] salt;
  int          obs_cnt [256];
  logic [47:0] exp_q[$];
  int          exp_core_q[$];

  // hash core responders
  bit          rsp_run [NC];
  int          rsp_age [NC];
  int          rsp_lat [NC];
  logic [7:0]  rsp_n   [NC];
  int          lat_mode;
  int          lat_tab [NC];

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_st[i] = 0; m_nonce[i] = 0; m_dcyc[i] = 0;
    end
    m_ptr = 0; m_num = 0; m_next = 0; m_act = 1'b0; m_base = '0;
    exp_q.delete();
    exp_core_q.delete();
  endtask

  function automatic int npend();
    int p = 0;
    for (int i = 0; i < NC; i++) if (m_st[i] == 2) p++;
    return p;
  endfunction

  // A core drops its old valid two cycles after start and raises the new
  // result after its latency.
  task automatic rsp_tick();
    for (int i = 0; i < NC; i++) begin
      if (core_start[i]) begin
        rsp_run[i] = 1'b1;
        rsp_age[i] = 0;
        rsp_n[i]   = core_nonce[7:0];
        rsp_lat[i] = (lat_mode == 0) ? lat_tab[i] : int'($urandom_range(3, 30));
      end else if (rsp_run[i]) begin
        rsp_age[i]++;
        if (rsp_age[i] == 2) core_valid[i] = 1'b0;
        if (rsp_age[i] >= rsp_lat[i]) begin
          core_valid[i]          = 1'b1;
          core_hash[32*i +: 32]  = hash_fn(salt, int'(rsp_n[i]));
          rsp_run[i]             = 1'b0;
        end
      end
    end
  endtask

  // scoreboard: one call per cycle, at the negative edge
  task automatic model_cycle();
    bit          act_now, act_nxt, all_free;
    int          c, g, wc;
    logic [47:0] w;
    logic [15:0] d;
    act_now = m_act;
    act_nxt = m_act;
    check("done", 32'(done), 32'(!act_now));

    if (mem_we && act_now) begin
      d = mem_addr - m_base;
      if (int'(d) < m_num) obs_cnt[d[7:0]]++;
    end
    if (exp_q.size() > 0) begin
      w  = exp_q.pop_front();
      wc = exp_core_q.pop_front();
      check("mem_we", 32'(mem_we), 32'd1);
      check("mem_addr", 32'(mem_addr), 32'(w[47:32]));
      check("mem_data", mem_write_data, w[31:0]);
      m_st[wc] = 0;
    end else begin
      check("mem_we_quiet", 32'(mem_we), 32'd0);
    end

    c = -1;
    if (act_now && m_next < m_num)
      for (int i = NC - 1; i >= 0; i--) if (m_st[i] == 0) c = i;
    if (c >= 0) begin
      check("core_start", 32'(core_start), 32'(1 << c));
      check("core_nonce", core_nonce, 32'(m_next));
      m_st[c] = 1; m_nonce[c] = m_next; m_dcyc[c] = cyc; m_next++;
    end else begin
      check("core_start_quiet", 32'(core_start), 32'd0);
    end

    all_free = 1'b1;
    for (int i = 0; i < NC; i++) if (m_st[i] != 0) all_free = 1'b0;
    if (act_now && m_next == m_num && all_free) act_nxt = 1'b0;

    g = -1;
    for (int k = 0; k < NC; k++)
      if (g < 0 && m_st[(m_ptr + k) % NC] == 2) g = (m_ptr + k) % NC;
    if (g >= 0) begin
      exp_q.push_back({16'(m_base + 16'(m_nonce[g])), hash_fn(salt, m_nonce[g])});
      exp_core_q.push_back(g);
      m_st[g] = 3;
      m_ptr   = (g + 1) % NC;
    end

    rsp_tick();
    for (int i = 0; i < NC; i++)
      if (m_st[i] == 1 && core_valid[i] && cyc >= m_dcyc[i] + 2) m_st[i] = 2;

    if (!act_now && start) begin
      act_nxt = 1'b1;
      m_num   = int'(num_nonces);
      m_base  = output_addr;
      m_next  = 0;
      for (int i = 0; i < 256; i++) obs_cnt[i] = 0;
    end
    m_act = act_nxt;
    cyc++;
  endtask

  // driver tasks
  task automatic step(input logic st, input logic [7:0] n, input logic [15:0] a);
    @(negedge clk);
    start       = st;
    num_nonces  = n;
    output_addr = a;
    model_cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    start   = 1'b0;
    #1;
    check("rst_done", 32'(done), 32'd1);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_core_nonce", core_nonce, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data", mem_write_data, 32'd0);
    rsp_tick();
    repeat (2) begin
      @(negedge clk);
      rsp_tick();
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    model_cycle();
  endtask

  task automatic run_job(input int n, input logic [15:0] a, input bit strays);
    int b;
    salt = $urandom();
    step(1'b1, 8'(n), a);
    b = 0;
    while (m_act && b < 3000) begin
      if (strays && (b == 2 || $urandom_range(0, 15) == 0))
        step(1'b1, 8'($urandom_range(0, 255)), 16'($urandom()));
      else
        step(1'b0, 8'(n), a);
      b++;
    end
    check("job_finished", 32'(m_act), 32'd0);
    for (int i = 0; i < n; i++) check("written_once", 32'(obs_cnt[i]), 32'd1);
    repeat (2) step(1'b0, 8'(n), a);
  endtask

  initial begin
    int b;
    reset_n     = 1'b0;
    start       = 1'b0;
    num_nonces  = '0;
    output_addr = '0;
    core_valid  = '0;
    core_hash   = '0;
    cyc         = 0;
    salt        = '0;
    lat_mode    = 0;
    lat_tab     = '{10, 10, 10, 10};
    for (int i = 0; i < NC; i++) begin
      rsp_run[i] = 1'b0; rsp_age[i] = 0; rsp_lat[i] = 0; rsp_n[i] = '0;
    end
    for (int i = 0; i < 256; i++) obs_cnt[i] = 0;
    model_reset();

    do_reset();
    repeat (2) step(1'b0, 8'd0, 16'h0);

    // empty job
    run_job(0, 16'h1234, 1'b0);
    // four nonces, equal long latency
    lat_tab = '{70, 70, 70, 70};
    run_job(4, 16'h0100, 1'b0);
    // fast core 0 gets reused; ignored start requests mid-job
    lat_tab = '{3, 50, 50, 50};
    run_job(10, 16'h2000, 1'b1);
    // all cores finish together, two batches
    lat_tab = '{13, 12, 11, 10};
    run_job(8, 16'h3000, 1'b0);
    // address wrap
    lat_tab = '{20, 7, 33, 5};
    run_job(4, 16'hFFFE, 1'b0);

    // reset while flushing with two results held
    lat_tab = '{11, 10, 60, 60};
    salt = $urandom();
    step(1'b1, 8'd4, 16'h5000);
    b = 0;
    while (npend() < 2 && b < 300) begin
      step(1'b0, 8'd4, 16'h5000);
      b++;
    end
    check("flush_state", 32'(dbg_state), 32'd2);
    do_reset();
    lat_tab = '{5, 5, 5, 5};
    run_job(2, 16'h4000, 1'b0);
    repeat (80) step(1'b0, 8'd2, 16'h4000);

    // randomized jobs
    lat_mode = 1;
    repeat (12) run_job(int'($urandom_range(0, 40)), 16'($urandom()), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
